// File: rtl/alu_exec_stage_pkg.sv
// Shared definitions for the ALU execute stage: opcode constants,
// occupancy state encoding and buffered entry layout.
package alu_exec_stage_pkg;

    // ALU opcodes, shared with the alu and the decode stage
    localparam logic [2:0] OC_ADD = 3'd0;
    localparam logic [2:0] OC_SUB = 3'd1;
    localparam logic [2:0] OC_MUL = 3'd2;
    localparam logic [2:0] OC_DIV = 3'd3;
    localparam logic [2:0] OC_NOT = 3'd4;
    localparam logic [2:0] OC_XOR = 3'd5;
    localparam logic [2:0] OC_OR  = 3'd6;
    localparam logic [2:0] OC_AND = 3'd7;

    // Elastic buffer occupancy
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_t;

    // A buffered entry is {f, oc, dz}: DATA_WIDTH + 3 + 1 bits
    localparam int ENTRY_EXTRA_W = 4;

endpackage : alu_exec_stage_pkg

// File: rtl/alu_exec_stage_alu.sv
// Combinational ALU. Results are truncated to DATA_WIDTH; division is
// unsigned and a zero divisor yields a zero result.
module alu_exec_stage_alu
    import alu_exec_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [2:0]            i_oc,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_f
);

    logic w_b_zero;

    assign w_b_zero = (i_b == {DATA_WIDTH{1'b0}});

    // Evaluate the selected operation on the two operands
    always_comb begin
        o_f = {DATA_WIDTH{1'b0}};
        case (i_oc)
            OC_ADD:  o_f = i_a + i_b;
            OC_SUB:  o_f = i_a - i_b;
            OC_MUL:  o_f = i_a * i_b;
            OC_DIV: begin
                if (w_b_zero) begin
                    o_f = {DATA_WIDTH{1'b0}};
                end else begin
                    o_f = i_a / i_b;
                end
            end
            OC_NOT:  o_f = ~i_a;
            OC_XOR:  o_f = i_a ^ i_b;
            OC_OR:   o_f = i_a | i_b;
            OC_AND:  o_f = i_a & i_b;
            default: o_f = {DATA_WIDTH{1'b0}};
        endcase
    end

endmodule : alu_exec_stage_alu

// File: rtl/alu_exec_stage.sv
// Registered execute stage: evaluates requests through the ALU and holds
// results in a 2-entry elastic buffer (output register + skid register),
// giving registered outputs, full throughput and a registered in_ready.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_oc,
    input  logic [DATA_WIDTH-1:0]  in_a,
    input  logic [DATA_WIDTH-1:0]  in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_f,
    output logic [2:0]             out_oc,
    output logic                   out_dz,
    output logic [COUNT_WIDTH-1:0] ops_count
);

    localparam int ENTRY_W = DATA_WIDTH + ENTRY_EXTRA_W;

    occ_state_t             r_state;
    logic                   r_out_valid;
    logic                   r_in_ready;
    logic [ENTRY_W-1:0]     r_out_entry;
    logic [ENTRY_W-1:0]     r_skid_entry;
    logic                   r_skid_valid;
    logic [COUNT_WIDTH-1:0] r_ops_count;

    logic [DATA_WIDTH-1:0]  w_alu_f;
    logic                   w_dz;
    logic [ENTRY_W-1:0]     w_entry;
    logic                   w_accept;
    logic                   w_release;

    alu_exec_stage_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .i_oc (in_oc),
        .i_a  (in_a),
        .i_b  (in_b),
        .o_f  (w_alu_f)
    );

    assign w_dz      = (in_oc == OC_DIV) && (in_b == {DATA_WIDTH{1'b0}});
    assign w_entry   = {w_alu_f, in_oc, w_dz};
    assign w_accept  = in_valid && r_in_ready;
    assign w_release = r_out_valid && out_ready;

    // Occupancy FSM: moves entries through output and skid registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_out_valid  <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_entry  <= {ENTRY_W{1'b0}};
            r_skid_entry <= {ENTRY_W{1'b0}};
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            // Drops everything buffered and any request accepted this cycle
            r_state      <= ST_EMPTY;
            r_out_valid  <= 1'b0;
            r_in_ready   <= 1'b1;
            r_skid_entry <= {ENTRY_W{1'b0}};
            r_skid_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_out_entry <= w_entry;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                    r_in_ready <= 1'b1;
                end
                ST_ONE: begin
                    case ({w_accept, w_release})
                        2'b11: begin
                            r_out_entry <= w_entry;
                            r_in_ready  <= 1'b1;
                        end
                        2'b10: begin
                            r_skid_entry <= w_entry;
                            r_skid_valid <= 1'b1;
                            r_state      <= ST_FULL;
                            r_in_ready   <= 1'b0;
                        end
                        2'b01: begin
                            r_out_valid <= 1'b0;
                            r_state     <= ST_EMPTY;
                            r_in_ready  <= 1'b1;
                        end
                        default: begin
                            r_in_ready <= 1'b1;
                        end
                    endcase
                end
                ST_FULL: begin
                    if (w_release) begin
                        r_out_entry  <= r_skid_entry;
                        r_skid_valid <= 1'b0;
                        r_state      <= ST_ONE;
                        r_in_ready   <= 1'b1;
                    end else begin
                        r_in_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_EMPTY;
                    r_out_valid  <= 1'b0;
                    r_in_ready   <= 1'b1;
                    r_skid_valid <= 1'b0;
                end
            endcase
        end
    end

    // Retired-operation counter; a release in a flush cycle still counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ops_count <= {COUNT_WIDTH{1'b0}};
        end else if (w_release) begin
            r_ops_count <= r_ops_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_ops_count <= r_ops_count;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_f     = r_out_entry[ENTRY_W-1 -: DATA_WIDTH];
    assign out_oc    = r_out_entry[3:1];
    assign out_dz    = r_out_entry[0];
    assign ops_count = r_ops_count;

endmodule : alu_exec_stage

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed steps followed by a
// randomized phase, all checked against a queue-based reference model.
module tb_alu_exec_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_oc;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_f;
    logic [2:0]  out_oc;
    logic        out_dz;
    logic [15:0] ops_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: FIFO of expected {f, oc, dz} and a release count
    logic [19:0] q[$];
    logic [15:0] m_cnt = 16'd0;

    alu_exec_stage #(
        .DATA_WIDTH  (16),
        .COUNT_WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_oc     (in_oc),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_f     (out_f),
        .out_oc    (out_oc),
        .out_dz    (out_dz),
        .ops_count (ops_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_alu(input int oc, input longint a, input longint b);
        longint r;
        case (oc)
            0: r = (a + b) % 65536;
            1: r = (a - b + 65536) % 65536;
            2: r = (a * b) % 65536;
            3: r = (b == 0) ? 0 : a / b;
            4: r = 65535 - a;
            5: r = a ^ b;
            6: r = a | b;
            7: r = a & b;
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Compare all DUT outputs against the model
    task automatic check_model(input string tag);
        logic [19:0] e;
        check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, (q.size() > 0)});
        check({tag, "_ready"}, {31'd0, in_ready}, {31'd0, (q.size() < 2)});
        check({tag, "_cnt"}, {16'd0, ops_count}, {16'd0, m_cnt});
        if (q.size() > 0) begin
            e = q[0];
            check({tag, "_f"}, {16'd0, out_f}, {16'd0, e[19:4]});
            check({tag, "_oc"}, {29'd0, out_oc}, {29'd0, e[3:1]});
            check({tag, "_dz"}, {31'd0, out_dz}, {31'd0, e[0]});
        end
    endtask

    // One clock: drive inputs, advance model, check after the edge
    task automatic step(input logic v, input logic [2:0] oc, input logic [15:0] a,
                        input logic [15:0] b, input logic ordy, input logic fl,
                        input string tag);
        logic rel;
        logic acc;
        logic [15:0] f;
        in_valid  = v;
        in_oc     = oc;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        flush     = fl;
        rel = (q.size() > 0) && ordy;
        acc = v && (q.size() < 2);
        f   = ref_alu(int'(oc), longint'(a), longint'(b));
        @(posedge clk);
        #1;
        if (rel) begin
            m_cnt = m_cnt + 16'd1;
            void'(q.pop_front());
        end
        if (fl) begin
            q.delete();
        end else if (acc) begin
            q.push_back({f, oc, (oc == 3'd3) && (b == 16'd0)});
        end
        check_model(tag);
    endtask

    initial begin
        logic [15:0] stream_exp [8];
        logic [15:0] base;
        stream_exp[0] = 16'd17;   stream_exp[1] = 16'd7;
        stream_exp[2] = 16'd60;   stream_exp[3] = 16'd2;
        stream_exp[4] = 16'hFFF3; stream_exp[5] = 16'd9;
        stream_exp[6] = 16'd13;   stream_exp[7] = 16'd4;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_oc = 3'd0;
        in_a = 16'd0; in_b = 16'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_f", {16'd0, out_f}, 32'd0);
        check("rst_oc", {29'd0, out_oc}, 32'd0);
        check("rst_dz", {31'd0, out_dz}, 32'd0);
        check("rst_cnt", {16'd0, ops_count}, 32'd0);
        rst_n = 1'b1;

        // Single ADD with overflow into the sign bit
        step(1'b1, 3'd0, 16'h7FFF, 16'h0001, 1'b1, 1'b0, "add");
        check("add_const_f", {16'd0, out_f}, 32'h8000);
        step(1'b0, 3'd0, 16'd0, 16'd0, 1'b1, 1'b0, "add_rel");
        check("add_const_cnt", {16'd0, ops_count}, 32'd1);

        // Divide by zero, then multiply wrap
        step(1'b1, 3'd3, 16'd100, 16'd0, 1'b1, 1'b0, "divz");
        check("divz_const_f", {16'd0, out_f}, 32'd0);
        check("divz_const_dz", {31'd0, out_dz}, 32'd1);
        step(1'b1, 3'd2, 16'h0100, 16'h0100, 1'b1, 1'b0, "mulw");
        check("mulw_const_f", {16'd0, out_f}, 32'd0);
        check("mulw_const_dz", {31'd0, out_dz}, 32'd0);
        step(1'b0, 3'd0, 16'd0, 16'd0, 1'b1, 1'b0, "drain1");

        // Backpressure fills the buffer; results leave in order
        step(1'b1, 3'd1, 16'd10, 16'd3, 1'b0, 1'b0, "bp_sub");
        step(1'b1, 3'd5, 16'h00F0, 16'h000F, 1'b0, 1'b0, "bp_xor");
        check("bp_const_ready", {31'd0, in_ready}, 32'd0);
        check("bp_const_f", {16'd0, out_f}, 32'd7);
        step(1'b1, 3'd0, 16'd1, 16'd1, 1'b0, 1'b0, "bp_hold");
        check("bp_hold_f", {16'd0, out_f}, 32'd7);
        step(1'b0, 3'd0, 16'd0, 16'd0, 1'b1, 1'b0, "bp_rel1");
        check("bp_rel1_f", {16'd0, out_f}, 32'h00FF);
        check("bp_rel1_ready", {31'd0, in_ready}, 32'd1);
        step(1'b0, 3'd0, 16'd0, 16'd0, 1'b1, 1'b0, "bp_rel2");

        // Streaming: one op per cycle, every opcode
        base = m_cnt;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'(i), 16'd12, 16'd5, 1'b1, 1'b0, "stream");
            check("stream_const_f", {16'd0, out_f}, {16'd0, stream_exp[i]});
        end
        step(1'b0, 3'd0, 16'd0, 16'd0, 1'b1, 1'b0, "stream_end");
        check("stream_const_cnt", {16'd0, ops_count - base}, 32'd8);

        // Flush while full with a request offered
        step(1'b1, 3'd0, 16'd1, 16'd1, 1'b0, 1'b0, "fl_a");
        step(1'b1, 3'd0, 16'd2, 16'd2, 1'b0, 1'b0, "fl_b");
        base = m_cnt;
        step(1'b1, 3'd0, 16'd3, 16'd3, 1'b0, 1'b1, "flush");
        check("flush_const_valid", {31'd0, out_valid}, 32'd0);
        check("flush_const_ready", {31'd0, in_ready}, 32'd1);
        check("flush_const_cnt", {16'd0, ops_count}, {16'd0, base});
        step(1'b0, 3'd0, 16'd0, 16'd0, 1'b1, 1'b0, "flush_after");

        // Asynchronous reset while full, between clock edges
        step(1'b1, 3'd6, 16'd4, 16'd1, 1'b0, 1'b0, "ar_a");
        step(1'b1, 3'd7, 16'd6, 16'd3, 1'b0, 1'b0, "ar_b");
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_ready", {31'd0, in_ready}, 32'd1);
        check("arst_cnt", {16'd0, ops_count}, 32'd0);
        q.delete();
        m_cnt = 16'd0;
        #2;
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [15:0] rb;
            rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom), rb,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alu_exec_stage

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered execute stage wrapped around the existing combinational ALU.
- Accepts operation requests (oc, a, b) from the decode/operand-fetch stage over a valid/ready handshake and evaluates them through an instantiated alu.
- Holds results in a 2-entry elastic buffer, so the writeback stage sees registered results, full throughput, and no combinational ready path.
- Counts retired operations and flags divide-by-zero.

Parameters:
- DATA_WIDTH, 16, operand/result width; passed to the alu instance.
- COUNT_WIDTH, 16, width of the retired-operation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of buffered results.
- in_valid  in  1  request valid.
- in_ready  out  1  stage can accept a request; registered.
- in_oc  in  3  ALU opcode (ADD=0, SUB=1, MUL=2, DIV=3, NOT=4, XOR=5, OR=6, AND=7).
- in_a  in  DATA_WIDTH  operand a.
- in_b  in  DATA_WIDTH  operand b.
- out_valid  out  1  result valid; registered.
- out_ready  in  1  downstream accepts result.
- out_f  out  DATA_WIDTH  result.
- out_oc  out  3  opcode of the result.
- out_dz  out  1  result came from DIV with b==0 (out_f is 0 in that case).
- ops_count  out  COUNT_WIDTH  number of completed output handshakes.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_f=0, out_oc=0, out_dz=0, ops_count=0, in_ready=1, skid entry invalid, state EMPTY.
- Accept: in_valid && in_ready at a clock edge.
  - Result = alu(in_oc, in_a, in_b), computed combinationally in the accept cycle.
  - dz = (in_oc==DIV && in_b==0).
  - The entry {f, oc, dz} is captured at that edge.
- Release: out_valid && out_ready at a clock edge.
- Latency: an accepted request appears on out_* in the next cycle when the stage is EMPTY, or when it is ONE and releasing in the same cycle.
- Throughput: one op per clock with out_ready held high.
- Results leave strictly in acceptance order.
- State machine (occupancy):
  - EMPTY: out_valid=0, in_ready=1.
    - Accept -> ONE, entry loaded into the output register.
  - ONE: out_valid=1, in_ready=1.
    - Accept and release -> ONE; the new entry replaces the output register.
    - Accept only -> FULL; new entry loaded into the skid register, output register unchanged.
    - Release only -> EMPTY.
    - Neither -> ONE.
  - FULL: out_valid=1, in_ready=0.
    - Release -> ONE; skid entry moves into the output register.
    - Otherwise hold.
- in_ready is registered and equals "next state != FULL".
- While out_valid=1 and out_ready=0, out_f/out_oc/out_dz must remain stable.
- flush (priority over everything except reset):
  - Next state EMPTY, out_valid=0, skid cleared, in_ready=1.
  - Any request accepted in the flush cycle is discarded.
  - A release in the flush cycle still counts (ops_count increments).
  - out_f/out_oc/out_dz are not required to clear.
- ops_count increments by 1 on each release and wraps from 2^COUNT_WIDTH-1 to 0 with no flag.
- Arithmetic: all alu results are truncated to DATA_WIDTH (ADD/SUB/MUL wrap modulo 2^DATA_WIDTH); DIV is unsigned; DIV by 0 yields 0 with dz=1.
- Unknown opcodes cannot occur, since all 8 codes are defined.
- Reset asserted mid-operation drops all buffered entries immediately; there is no partial-state retention.

Decomposition:
- Shared package:
  - Opcode constants ADD..AND (3-bit), also used by alu and decode.
  - Occupancy state encoding EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
  - Entry width constant DATA_WIDTH+4 ({f, oc, dz}).
- Sub-module: instantiate the existing alu (DATA_WIDTH forwarded) for the combinational evaluation.
- The elastic buffer stays inline; it is small enough not to warrant its own module.

Test Plan:
- Reset then single op: in_oc=ADD, a=16'h7FFF, b=16'h0001, out_ready=1 -> next cycle out_valid=1, out_f=16'h8000, out_oc=0, out_dz=0; ops_count=1 after the release.
- Divide-by-zero and wrap: DIV a=100, b=0 -> out_f=0, out_dz=1; then MUL a=16'h0100, b=16'h0100 -> out_f=16'h0000, out_dz=0.
- Backpressure: out_ready=0, issue SUB 10-3 then XOR F0^0F -> in_ready drops to 0 after the 2nd accept, out_f holds 7. Raise out_ready -> outputs 7, then 16'h00FF in order; in_ready returns to 1.
- Streaming: 8 back-to-back ops (one per opcode, a=12, b=5) with out_ready=1 -> 8 results on consecutive cycles: 17, 7, 60, 2, 16'hFFF3, 9, 13, 4; ops_count=8.
- Flush: fill to FULL, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped request never appears, ops_count unchanged.
- Async reset mid-stream: drop rst_n between clock edges while FULL -> out_valid=0, in_ready=1, ops_count=0 immediately, without waiting for a clock edge.
